// File: rtl/pipe_if.sv
// ---------------------------------------------------------------------------
// pipe_if -- RV32I instruction-fetch stage.
//
// Fetches each 32-bit instruction as four little-endian bytes from a
// byte-wide memory port. Hands {inst, pc_out} to decode over a 4-phase
// down_syn/down_ack handshake. Accepts PC redirects from the execute stage.
//
// Optional feature macro: IF_MISALIGN_CHK_EN
//   defined   -> an unaligned PC is not fetched. NOP_INST is delivered with
//                misalign=1 instead.
//   undefined -> an unaligned PC is fetched byte-by-byte. misalign is tied 0.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   NOP_INST   instruction substituted for a misaligned fetch (option only)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   mem_req    out  1   byte read request, held until mem_valid
//   mem_addr   out  32  byte address, stable while mem_req=1
//   mem_rdata  in   8   returned byte
//   mem_valid  in   1   one-cycle pulse, data for current mem_addr
//   redir_e    in   1   redirect strobe from execute
//   redir_pc   in   32  redirect target
//   down_syn   out  1   instruction available to decode
//   down_ack   in   1   decode acknowledge
//   inst       out  32  fetched instruction, stable while down_syn=1
//   pc_out     out  32  address of inst
//   misalign   out  1   delivered instruction came from an unaligned PC
// ---------------------------------------------------------------------------
module pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IF_MISALIGN_CHK_EN
    , parameter logic [31:0] NOP_INST = 32'h0000_0013
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    input  logic        redir_e,
    input  logic [31:0] redir_pc,
    output logic        down_syn,
    input  logic        down_ack,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        misalign
);

    typedef enum logic [1:0] {FETCH, OFFER, RELEASE} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_tgt;
    logic        redir_pend;
    logic [1:0]  byte_cnt;

`ifdef IF_MISALIGN_CHK_EN
    logic        mis_flag;
    assign misalign = mis_flag;
`else
    assign misalign = 1'b0;
`endif

    // A FETCH cycle with mem_req low is the entry cycle, where no byte is outstanding.
    // Once a byte is outstanding, the address is held until that byte returns.
    // A redirect that arrives meanwhile is parked in redir_pend/redir_tgt.
    // The returned byte is then dropped.
    // On the last byte the stage moves to OFFER, so down_syn rises
    // five cycles after FETCH entry when memory has zero wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            redir_tgt  <= 32'h0;
            redir_pend <= 1'b0;
            byte_cnt   <= 2'd0;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
            down_syn   <= 1'b0;
            inst       <= 32'h0;
            pc_out     <= 32'h0;
`ifdef IF_MISALIGN_CHK_EN
            mis_flag   <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        if (redir_e) begin
                            pc       <= redir_pc;
                            byte_cnt <= 2'd0;
`ifdef IF_MISALIGN_CHK_EN
                        end else if (pc[1:0] != 2'b00) begin
                            inst     <= NOP_INST;
                            mis_flag <= 1'b1;
                            pc_out   <= pc;
                            down_syn <= 1'b1;
                            state    <= OFFER;
`endif
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            byte_cnt <= 2'd0;
                        end
                    end else if (mem_valid) begin
                        if (redir_e || redir_pend) begin
                            // The byte belongs to an abandoned fetch, so it is dropped.
                            // A same-cycle redirect beats a parked redirect.
                            pc         <= redir_e ? redir_pc : redir_tgt;
                            redir_pend <= 1'b0;
                            byte_cnt   <= 2'd0;
                            mem_req    <= 1'b0;
                        end else begin
                            inst[{byte_cnt, 3'b000} +: 8] <= mem_rdata;
                            if (byte_cnt == 2'd3) begin
                                mem_req  <= 1'b0;
                                byte_cnt <= 2'd0;
                                pc_out   <= pc;
                                down_syn <= 1'b1;
                                state    <= OFFER;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                mem_addr <= mem_addr + 32'd1;
                            end
                        end
                    end else if (redir_e) begin
                        redir_pend <= 1'b1;
                        redir_tgt  <= redir_pc;
                    end
                end

                OFFER: begin
                    if (redir_e) begin
                        redir_pend <= 1'b1;
                        redir_tgt  <= redir_pc;
                    end
                    if (down_ack) begin
                        down_syn <= 1'b0;
                        state    <= RELEASE;
                    end
                end

                RELEASE: begin
                    // When the handshake closes, the next PC is chosen.
                    // A redirect in this same cycle is newest, then a parked
                    // redirect, then sequential flow (which wraps at 2^32).
                    if (!down_ack) begin
                        pc         <= redir_e ? redir_pc :
                                      (redir_pend ? redir_tgt : pc + 32'd4);
                        redir_pend <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
                        mis_flag   <= 1'b0;
`endif
                        state      <= FETCH;
                    end else if (redir_e) begin
                        redir_pend <= 1'b1;
                        redir_tgt  <= redir_pc;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_if.sv
// ---------------------------------------------------------------------------
// tb_pipe_if -- self-checking bench for pipe_if.
//
// Roles in this bench:
//   - A byte memory with random latency. Its contents are a fixed function of the address.
//   - A decode-side driver. It acks with random delays and fires random redirects.
//   - A scoreboard monitor. It compares every offered {pc_out, inst, misalign}
//     against the queue of expected deliveries.
//
// Model used for the expected values:
//   Every delivery is the instruction at the expected PC, and the next expected PC is PC+4.
//   A redirect replaces the newest undelivered expectation with the target.
//   If the fetch of that expectation was in flight, it is abandoned.
//   If a handshake was already under way, the instruction being handed over is still delivered.
// ---------------------------------------------------------------------------
module tb_pipe_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        redir_e;
    logic [31:0] redir_pc;
    logic        down_syn;
    logic        down_ack;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        misalign;

    pipe_if dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .redir_e   (redir_e),
        .redir_pc  (redir_pc),
        .down_syn  (down_syn),
        .down_ack  (down_ack),
        .inst      (inst),
        .pc_out    (pc_out),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } item_t;

    item_t       exp_q[$];
    item_t       cur_item;
    int          compared   = 0;
    int          mismatched = 0;
    int          delivered  = 0;
    logic [31:0] tail_pc;
    bit          hs;
    bit          exit_next;
    bit          zero_lat;
    int          wait_cnt;

    // Memory contents: addresses 0..3 hold ADDI x0,x0,0. Other bytes are hashed from the address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] t;
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        t = (a * 32'd37) ^ (a >> 8) ^ 32'h0000_00A5;
        return t[7:0];
    endfunction

    // Builds the expected delivery for a PC from memory contents (little-endian).
    function automatic item_t make_item(input logic [31:0] pc);
        item_t it;
        it.pc   = pc;
        it.mis  = 1'b0;
        it.inst = {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
                   mem_byte(pc + 32'd1), mem_byte(pc)};
`ifdef IF_MISALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
            it.inst = NOP_INST;
            it.mis  = 1'b1;
        end
`endif
        return it;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'hFFFF_FFFC;
            3: return 32'h0000_0102;
            default: begin
                r = $urandom_range(0, 1023);
                return r << 2;
            end
        endcase
    endfunction

    task automatic check_output(input string name, input logic [64:0] actual,
                                input logic [64:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Memory responder: answers a held request after 0..2 idle cycles.
    // Zero-wait mode gives the best-case timing.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (rst) begin
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_byte(mem_addr);
                    wait_cnt  = zero_lat ? 0 : int'($urandom_range(0, 2));
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Scoreboard monitor: pops one expectation on each rising down_syn.
    // It holds the value until the handshake ends.
    int  idle_cycles = 0;
    bit  prev_syn    = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_syn    = 1'b0;
            idle_cycles = 0;
        end else begin
            if (down_syn && !prev_syn) begin
                idle_cycles = 0;
                delivered++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_delivery: got pc_out=%h inst=%h, want none",
                             pc_out, inst);
                end else begin
                    cur_item = exp_q.pop_front();
                    check_output("delivery", {pc_out, inst, misalign},
                                 {cur_item.pc, cur_item.inst, cur_item.mis});
                end
            end else if (down_syn) begin
                check_output("inst_stable", {33'b0, inst}, {33'b0, cur_item.inst});
            end else begin
                idle_cycles++;
                if (idle_cycles > 400) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL timeout: got %0d idle cycles, want at most 400",
                             idle_cycles);
                    idle_cycles = 0;
                end
            end
            prev_syn = down_syn;
        end
    end

    // One cycle of decode-side stimulus, plus model upkeep for the redirect rule.
    task automatic apply_stimulus(input bit allow_redir);
        @(posedge clk);
        #1;
        redir_e = 1'b0;
        if (exit_next) begin
            hs        = 1'b0;
            exit_next = 1'b0;
        end
        if (!hs && down_syn) begin
            hs      = 1'b1;
            tail_pc = tail_pc + 32'd4;
            exp_q.push_back(make_item(tail_pc));
        end
        if (hs) begin
            if (down_syn && !down_ack) begin
                if ($urandom_range(0, 2) == 0) down_ack = 1'b1;
            end else if (!down_syn && down_ack) begin
                if ($urandom_range(0, 2) == 0) begin
                    down_ack  = 1'b0;
                    exit_next = 1'b1;
                end
            end
        end
        if (allow_redir && $urandom_range(0, 11) == 0) begin
            redir_e  = 1'b1;
            redir_pc = pick_target();
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            tail_pc = redir_pc;
            exp_q.push_back(make_item(redir_pc));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_mem_req"},  {64'b0, mem_req},  65'd0);
        check_output({tag, "_mem_addr"}, {33'b0, mem_addr}, {33'b0, RESET_PC});
        check_output({tag, "_down_syn"}, {64'b0, down_syn}, 65'd0);
        check_output({tag, "_inst"},     {33'b0, inst},     65'd0);
        check_output({tag, "_pc_out"},   {33'b0, pc_out},   65'd0);
        check_output({tag, "_misalign"}, {64'b0, misalign}, 65'd0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        tail_pc   = RESET_PC;
        exp_q.push_back(make_item(RESET_PC));
        hs        = 1'b0;
        exit_next = 1'b0;
        down_ack  = 1'b0;
        redir_e   = 1'b0;
    endtask

    initial begin
        int cycles;
        rst      = 1'b1;
        redir_pc = 32'h0;
        zero_lat = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        // First instruction with zero-wait memory: offered five cycles after FETCH entry.
        @(negedge clk);
        rst    = 1'b0;
        cycles = 0;
        while (!down_syn && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_output("first_offer_latency", 65'(cycles), 65'd5);

        zero_lat = 1'b0;
        for (int i = 0; i < 3000; i++) apply_stimulus(1'b1);

        // Let the stage settle into a plain fetch, then hit it with reset mid-byte.
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(1'b0);
            if (!hs && !exit_next && mem_req && !down_syn) break;
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) apply_stimulus(1'b1);

        check_output("deliveries_seen", {64'b0, delivered > 50}, 65'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
